multicycle_control_unit: RTL and testbench

Sequencing control unit for the multi-cycle RV32IM core. It replaces purely combinational decode with a FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK state machine. It handshakes with instruction memory, data memory and the iterative mul/div unit, and drives per-state datapath enables. It also keeps a parametrised retired-instruction counter.

---
 rtl/multicycle_control_unit.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32IM sequencing FSM (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK) with memory and mul/div handshakes.
// Define ILLEGAL_INSN_TRAP_EN to send illegal instructions to a sticky TRAP state instead of retiring them as NOPs.
module multicycle_control_unit #(
   parameter int unsigned RETIRE_CNT_W = 32,
   parameter bit          M_EXT        = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [31:0]             instr,
   output logic                    imem_req,
   input  logic                    imem_ready,
   output logic                    ir_write,
   output logic                    dmem_req,
   output logic                    dmem_we,
   input  logic                    dmem_ready,
   output logic [1:0]              data_size,
   output logic                    data_unsigned,
   output logic                    muldiv_start,
   input  logic                    muldiv_done,
   input  logic                    branch_cond,
   output logic [4:0]              alu_control,
   output logic                    alu_src_a,
   output logic                    alu_src_b,
   output logic [2:0]              imm_src,
   output logic [1:0]              result_src,
   output logic                    pc_target_base_src,
   output logic                    reg_write,
   output logic                    pc_write,
   output logic                    pc_src,
   output logic                    retire,
   output logic [RETIRE_CNT_W-1:0] instret,
   output logic                    trap
);

   localparam logic [2:0] S_RST       = 3'd0;
   localparam logic [2:0] S_FETCH     = 3'd1;
   localparam logic [2:0] S_DECODE    = 3'd2;
   localparam logic [2:0] S_EXECUTE   = 3'd3;
   localparam logic [2:0] S_MEMORY    = 3'd4;
   localparam logic [2:0] S_WRITEBACK = 3'd5;
`ifdef ILLEGAL_INSN_TRAP_EN
   localparam logic [2:0] S_TRAP      = 3'd6;
`endif

   localparam logic [4:0] ALU_UNDEFINED = 5'd0;
   localparam logic [4:0] ALU_ADD    = 5'd1;
   localparam logic [4:0] ALU_SUB    = 5'd2;
   localparam logic [4:0] ALU_SLL    = 5'd3;
   localparam logic [4:0] ALU_SLT    = 5'd4;
   localparam logic [4:0] ALU_SLTU   = 5'd5;
   localparam logic [4:0] ALU_XOR    = 5'd6;
   localparam logic [4:0] ALU_SRL    = 5'd7;
   localparam logic [4:0] ALU_SRA    = 5'd8;
   localparam logic [4:0] ALU_OR     = 5'd9;
   localparam logic [4:0] ALU_AND    = 5'd10;
   localparam logic [4:0] ALU_EQ     = 5'd11;
   localparam logic [4:0] ALU_NE     = 5'd12;
   localparam logic [4:0] ALU_LT     = 5'd13;
   localparam logic [4:0] ALU_GE     = 5'd14;
   localparam logic [4:0] ALU_LTU    = 5'd15;
   localparam logic [4:0] ALU_GEU    = 5'd16;
   localparam logic [4:0] ALU_PASS_B = 5'd17;
   localparam logic [4:0] ALU_MUL    = 5'd18;

   localparam logic ALU_SRC_A_UNDEFINED = 1'b0;
   localparam logic ALU_SRC_A_RS1       = 1'b0;
   localparam logic ALU_SRC_A_PC        = 1'b1;
   localparam logic ALU_SRC_B_UNDEFINED = 1'b0;
   localparam logic ALU_SRC_B_RS2       = 1'b0;
   localparam logic ALU_SRC_B_IMM       = 1'b1;

   localparam logic [2:0] IMM_UNDEFINED = 3'd0;
   localparam logic [2:0] IMM_I = 3'd1;
   localparam logic [2:0] IMM_S = 3'd2;
   localparam logic [2:0] IMM_B = 3'd3;
   localparam logic [2:0] IMM_U = 3'd4;
   localparam logic [2:0] IMM_J = 3'd5;

   localparam logic [1:0] RESULT_SRC_UNDEFINED = 2'd0;
   localparam logic [1:0] RESULT_SRC_ALU       = 2'd1;
   localparam logic [1:0] RESULT_SRC_LOAD      = 2'd2;
   localparam logic [1:0] RESULT_SRC_PC4       = 2'd3;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic logic [4:0] branch_alu(input logic [2:0] f3);
      case (f3)
         3'b000:  return ALU_EQ;
         3'b001:  return ALU_NE;
         3'b100:  return ALU_LT;
         3'b101:  return ALU_GE;
         3'b110:  return ALU_LTU;
         default: return ALU_GEU;
      endcase
   endfunction

   logic [2:0] state, next_state;
   logic       md_busy;
   logic [6:0] opcode, funct7;
   logic [2:0] funct3;
   logic       is_branch, is_load, is_store, is_jal, is_jalr, decode_active;
   logic       dec_legal, dec_muldiv, dec_src_a, dec_src_b, dec_base_pc;
   logic [4:0] dec_alu;
   logic [2:0] dec_imm;
   logic [1:0] dec_result;
   logic       unused_instr_bits;

   assign opcode    = instr[6:0];
   assign funct3    = instr[14:12];
   assign funct7    = instr[31:25];
   assign is_branch = (opcode == OPC_BRANCH);
   assign is_load   = (opcode == OPC_LOAD);
   assign is_store  = (opcode == OPC_STORE);
   assign is_jal    = (opcode == OPC_JAL);
   assign is_jalr   = (opcode == OPC_JALR);
   assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

   // Static RV32IM decode of the latched instruction, including the legality check.
   always_comb begin
      dec_legal   = 1'b0;
      dec_muldiv  = 1'b0;
      dec_alu     = ALU_UNDEFINED;
      dec_src_a   = ALU_SRC_A_RS1;
      dec_src_b   = ALU_SRC_B_RS2;
      dec_imm     = IMM_UNDEFINED;
      dec_result  = RESULT_SRC_UNDEFINED;
      dec_base_pc = 1'b1;
      case (opcode)
         OPC_LUI: begin
            dec_legal = 1'b1; dec_alu = ALU_PASS_B; dec_src_b = ALU_SRC_B_IMM;
            dec_imm = IMM_U; dec_result = RESULT_SRC_ALU;
         end
         OPC_AUIPC: begin
            dec_legal = 1'b1; dec_alu = ALU_ADD; dec_src_a = ALU_SRC_A_PC;
            dec_src_b = ALU_SRC_B_IMM; dec_imm = IMM_U; dec_result = RESULT_SRC_ALU;
         end
         OPC_JAL: begin
            dec_legal = 1'b1; dec_imm = IMM_J; dec_result = RESULT_SRC_PC4;
         end
         OPC_JALR: begin
            dec_legal = (funct3 == 3'b000); dec_alu = ALU_ADD; dec_src_b = ALU_SRC_B_IMM;
            dec_imm = IMM_I; dec_result = RESULT_SRC_PC4; dec_base_pc = 1'b0;
         end
         OPC_BRANCH: begin
            dec_legal = (funct3[2:1] != 2'b01); dec_alu = branch_alu(funct3); dec_imm = IMM_B;
         end
         OPC_LOAD: begin
            dec_legal = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
            dec_alu = ALU_ADD; dec_src_b = ALU_SRC_B_IMM; dec_imm = IMM_I;
            dec_result = RESULT_SRC_LOAD;
         end
         OPC_STORE: begin
            dec_legal = !funct3[2] && (funct3[1:0] != 2'b11);
            dec_alu = ALU_ADD; dec_src_b = ALU_SRC_B_IMM; dec_imm = IMM_S;
         end
         OPC_OP_IMM: begin
            if (funct3 == 3'b001)      dec_legal = (funct7 == 7'b0000000);
            else if (funct3 == 3'b101) dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            else                       dec_legal = 1'b1;
            dec_alu = alu_from_f3(funct3, (funct3 == 3'b101) && instr[30]);
            dec_src_b = ALU_SRC_B_IMM; dec_imm = IMM_I; dec_result = RESULT_SRC_ALU;
         end
         OPC_OP: begin
            dec_result = RESULT_SRC_ALU;
            if (funct7 == 7'b0000000) begin
               dec_legal = 1'b1; dec_alu = alu_from_f3(funct3, 1'b0);
            end else if (funct7 == 7'b0100000) begin
               dec_legal = (funct3 == 3'b000) || (funct3 == 3'b101);
               dec_alu = alu_from_f3(funct3, 1'b1);
            end else if (funct7 == 7'b0000001) begin
               dec_legal = M_EXT; dec_muldiv = M_EXT;
               dec_alu = ALU_MUL + {2'b00, funct3};
            end
         end
         default: ;
      endcase
   end

   // Sequencing and handshake-qualified pulses; md_busy separates the start cycle from the wait cycles.
   always_comb begin
      next_state   = state;
      imem_req     = 1'b0;
      ir_write     = 1'b0;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      muldiv_start = 1'b0;
      reg_write    = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      retire       = 1'b0;
      case (state)
         S_RST: next_state = S_FETCH;
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_write   = 1'b1;
               next_state = S_DECODE;
            end
         end
         S_DECODE: begin
            if (dec_legal)  next_state = S_EXECUTE;
`ifdef ILLEGAL_INSN_TRAP_EN
            else            next_state = S_TRAP;
`else
            else            next_state = S_WRITEBACK;
`endif
         end
         S_EXECUTE: begin
            if (dec_muldiv) begin
               muldiv_start = !md_busy;
               if (md_busy && muldiv_done) next_state = S_WRITEBACK;
            end else if (is_branch) begin
               pc_write   = 1'b1;
               pc_src     = branch_cond;
               retire     = 1'b1;
               next_state = S_FETCH;
            end else if (is_load || is_store) begin
               next_state = S_MEMORY;
            end else begin
               next_state = S_WRITEBACK;
            end
         end
         S_MEMORY: begin
            dmem_req = 1'b1;
            dmem_we  = is_store;
            if (dmem_ready) begin
               if (is_store) begin
                  pc_write   = 1'b1;
                  retire     = 1'b1;
                  next_state = S_FETCH;
               end else begin
                  next_state = S_WRITEBACK;
               end
            end
         end
         S_WRITEBACK: begin
            reg_write  = dec_legal;
            pc_write   = 1'b1;
            pc_src     = dec_legal && (is_jal || is_jalr);
            retire     = 1'b1;
            next_state = S_FETCH;
         end
`ifdef ILLEGAL_INSN_TRAP_EN
         S_TRAP: next_state = S_TRAP;
`endif
         default: next_state = S_RST;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_RST;
         md_busy <= 1'b0;
         instret <= '0;
      end else begin
         state   <= next_state;
         md_busy <= (state == S_EXECUTE) && dec_muldiv && (next_state == S_EXECUTE);
         if (retire) instret <= instret + RETIRE_CNT_W'(1);
      end
   end

   // Decoded codes are only meaningful once the instruction register holds the instruction.
   assign decode_active      = (state == S_DECODE) || (state == S_EXECUTE) ||
                               (state == S_MEMORY) || (state == S_WRITEBACK);
   assign alu_control        = decode_active ? dec_alu     : ALU_UNDEFINED;
   assign alu_src_a          = decode_active ? dec_src_a   : ALU_SRC_A_UNDEFINED;
   assign alu_src_b          = decode_active ? dec_src_b   : ALU_SRC_B_UNDEFINED;
   assign imm_src            = decode_active ? dec_imm     : IMM_UNDEFINED;
   assign result_src         = decode_active ? dec_result  : RESULT_SRC_UNDEFINED;
   assign pc_target_base_src = decode_active ? dec_base_pc : 1'b0;
   assign data_size          = (decode_active && (is_load || is_store)) ? funct3[1:0] : 2'b00;
   assign data_unsigned      = decode_active && (is_load || is_store) && funct3[2];

`ifdef ILLEGAL_INSN_TRAP_EN
   assign trap = (state == S_TRAP);
`else
   assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit; a second instance checks M_EXT = 0 and a 4-bit instret.
module tb_multicycle_control_unit;

   localparam logic [31:0] I_ADDI = 32'h0050_0093;
   localparam logic [31:0] I_LW   = 32'h0000_A103;
   localparam logic [31:0] I_SW   = 32'h0020_A023;
   localparam logic [31:0] I_BEQ  = 32'h0020_8463;
   localparam logic [31:0] I_JAL  = 32'h0100_00EF;
   localparam logic [31:0] I_JALR = 32'h0000_8067;
   localparam logic [31:0] I_DIV  = 32'h0220_C1B3;
   localparam logic [31:0] I_MUL  = 32'h0220_81B3;
   localparam logic [31:0] I_BAD  = 32'h0000_007F;

   localparam logic [4:0] ALU_ADD = 5'd1;
   localparam logic [4:0] ALU_EQ  = 5'd11;
   localparam logic [4:0] ALU_DIV = 5'd22;
   localparam logic [2:0] IMM_I = 3'd1;
   localparam logic [2:0] IMM_S = 3'd2;
   localparam logic [2:0] IMM_B = 3'd3;
   localparam logic [2:0] IMM_J = 3'd5;
   localparam logic [1:0] RES_ALU = 2'd1;
   localparam logic [1:0] RES_LOAD = 2'd2;
   localparam logic [1:0] RES_PC4 = 2'd3;

   logic clk = 1'b0;
   logic rst_n, imem_ready, dmem_ready, muldiv_done, branch_cond;
   logic [31:0] instr;

   logic imem_req, ir_write, dmem_req, dmem_we, data_unsigned, muldiv_start;
   logic alu_src_a, alu_src_b, pc_target_base_src, reg_write, pc_write, pc_src, retire, trap;
   logic [1:0] data_size, result_src;
   logic [4:0] alu_control;
   logic [2:0] imm_src;
   logic [31:0] instret;

   logic imem_req_m0, ir_write_m0, dmem_req_m0, dmem_we_m0, data_unsigned_m0, muldiv_start_m0;
   logic alu_src_a_m0, alu_src_b_m0, pc_target_base_src_m0, reg_write_m0, pc_write_m0;
   logic pc_src_m0, retire_m0, trap_m0;
   logic [1:0] data_size_m0, result_src_m0;
   logic [4:0] alu_control_m0;
   logic [2:0] imm_src_m0;
   logic [3:0] instret_m0;

   int checks = 0;
   int errors = 0;

   int r_retire_cyc, r_start_cyc, r_imem_req, r_dmem_req, r_ir_write, r_reg_write, r_pc_write, r_md_start;
   logic r_timeout, r_pc_src, r_dmem_we, r_trap, r_base;
   logic [1:0] r_size, r_res;
   logic [4:0] r_alu;
   logic [2:0] r_imm;
   logic [31:0] r_first_instret;

   always #5 clk = ~clk;

   multicycle_control_unit #(.RETIRE_CNT_W(32), .M_EXT(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .imem_req(imem_req), .imem_ready(imem_ready),
      .ir_write(ir_write), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
      .data_size(data_size), .data_unsigned(data_unsigned), .muldiv_start(muldiv_start),
      .muldiv_done(muldiv_done), .branch_cond(branch_cond), .alu_control(alu_control),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src), .result_src(result_src),
      .pc_target_base_src(pc_target_base_src), .reg_write(reg_write), .pc_write(pc_write),
      .pc_src(pc_src), .retire(retire), .instret(instret), .trap(trap)
   );

   multicycle_control_unit #(.RETIRE_CNT_W(4), .M_EXT(1'b0)) dut_m0 (
      .clk(clk), .rst_n(rst_n), .instr(instr), .imem_req(imem_req_m0), .imem_ready(imem_ready),
      .ir_write(ir_write_m0), .dmem_req(dmem_req_m0), .dmem_we(dmem_we_m0), .dmem_ready(dmem_ready),
      .data_size(data_size_m0), .data_unsigned(data_unsigned_m0), .muldiv_start(muldiv_start_m0),
      .muldiv_done(muldiv_done), .branch_cond(branch_cond), .alu_control(alu_control_m0),
      .alu_src_a(alu_src_a_m0), .alu_src_b(alu_src_b_m0), .imm_src(imm_src_m0),
      .result_src(result_src_m0), .pc_target_base_src(pc_target_base_src_m0),
      .reg_write(reg_write_m0), .pc_write(pc_write_m0), .pc_src(pc_src_m0), .retire(retire_m0),
      .instret(instret_m0), .trap(trap_m0)
   );

   task automatic reset_dut();
      rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; muldiv_done = 1'b0; branch_cond = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Drives one instruction from its first FETCH cycle up to its retire cycle, recording what dut did.
   task automatic run_insn(input int imem_delay, input int dmem_delay, input int md_delay,
                           input logic bcond, input int budget);
      int imem_cnt, dmem_cnt;
      imem_cnt = 0; dmem_cnt = 0;
      r_retire_cyc = -1; r_start_cyc = -1; r_ir_write = 0; r_reg_write = 0; r_pc_write = 0;
      r_md_start = 0; r_timeout = 1'b1; r_pc_src = 1'b0; r_dmem_we = 1'b0; r_trap = 1'b0;
      r_size = 2'b00; r_res = 2'b00; r_alu = 5'd0; r_imm = 3'd0; r_base = 1'b0;
      r_imem_req = 0; r_dmem_req = 0; r_first_instret = 32'hFFFF_FFFF;
      branch_cond = bcond;
      for (int cyc = 0; cyc < budget; cyc++) begin
         @(posedge clk); #1;
         if (cyc == 0) r_first_instret = instret;
         if (muldiv_start) begin
            r_md_start++;
            if (r_start_cyc < 0) r_start_cyc = cyc;
         end
         imem_ready  = imem_req && (imem_cnt == imem_delay);
         dmem_ready  = dmem_req && (dmem_cnt == dmem_delay);
         muldiv_done = (r_start_cyc >= 0) && (cyc - r_start_cyc == md_delay);
         #1;
         if (imem_req) imem_cnt++;
         if (dmem_req) begin
            dmem_cnt++; r_dmem_we = dmem_we; r_size = data_size;
         end
         r_imem_req = imem_cnt; r_dmem_req = dmem_cnt;
         if (ir_write) r_ir_write++;
         if (reg_write) r_reg_write++;
         if (pc_write) begin r_pc_write++; r_pc_src = pc_src; end
         if (trap) r_trap = 1'b1;
         if (retire) begin
            r_retire_cyc = cyc; r_alu = alu_control; r_imm = imm_src; r_res = result_src;
            r_base = pc_target_base_src; r_timeout = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1; muldiv_done = 1'b0; branch_cond = 1'b1;
      instr = I_ADDI;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_imem_req: got %0b expected 0", imem_req); end
      checks++; if (alu_control !== 5'd0) begin errors++; $display("[TB] FAIL reset_alu_control: got %0d expected 0", alu_control); end
      checks++; if (result_src !== 2'd0 || imm_src !== 3'd0) begin errors++; $display("[TB] FAIL reset_codes: got res=%0d imm=%0d expected 0/0", result_src, imm_src); end
      checks++; if (instret !== 32'd0) begin errors++; $display("[TB] FAIL reset_instret: got %0d expected 0", instret); end
      checks++; if ({retire, reg_write, pc_write, ir_write, dmem_req, trap} !== 6'b0) begin errors++; $display("[TB] FAIL reset_pulses: got %b expected 000000", {retire, reg_write, pc_write, ir_write, dmem_req, trap}); end
      rst_n = 1'b1; #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_state_imem_req: got %0b expected 0", imem_req); end
   endtask

   task automatic test_alu_fetch();
      reset_dut(); instr = I_ADDI;
      run_insn(0, 0, 0, 1'b0, 20);
      checks++; if (r_retire_cyc !== 3) begin errors++; $display("[TB] FAIL addi_retire_cycle: got %0d expected 3", r_retire_cyc); end
      checks++; if (r_alu !== ALU_ADD || r_imm !== IMM_I) begin errors++; $display("[TB] FAIL addi_codes: got alu=%0d imm=%0d expected %0d/%0d", r_alu, r_imm, ALU_ADD, IMM_I); end
      checks++; if (r_reg_write !== 1 || r_pc_src !== 1'b0 || r_res !== RES_ALU) begin errors++; $display("[TB] FAIL addi_wb: got rw=%0d pc_src=%0b res=%0d expected 1/0/%0d", r_reg_write, r_pc_src, r_res, RES_ALU); end
      checks++; if (r_ir_write !== 1) begin errors++; $display("[TB] FAIL addi_ir_write: got %0d expected 1", r_ir_write); end
      @(posedge clk); #1;
      checks++; if (instret !== 32'd1 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL addi_instret: got %0d req=%0b expected 1/1", instret, imem_req); end
   endtask

   task automatic test_wait_states();
      reset_dut(); instr = I_LW;
      run_insn(3, 2, 0, 1'b0, 30);
      checks++; if (r_imem_req !== 4) begin errors++; $display("[TB] FAIL lw_imem_req_cycles: got %0d expected 4", r_imem_req); end
      checks++; if (r_dmem_req !== 3) begin errors++; $display("[TB] FAIL lw_dmem_req_cycles: got %0d expected 3", r_dmem_req); end
      checks++; if (r_dmem_we !== 1'b0 || r_size !== 2'b10) begin errors++; $display("[TB] FAIL lw_dmem_ctrl: got we=%0b size=%b expected 0/10", r_dmem_we, r_size); end
      checks++; if (r_retire_cyc !== 9 || r_reg_write !== 1) begin errors++; $display("[TB] FAIL lw_retire: got cyc=%0d rw=%0d expected 9/1", r_retire_cyc, r_reg_write); end
      checks++; if (r_res !== RES_LOAD) begin errors++; $display("[TB] FAIL lw_result_src: got %0d expected %0d", r_res, RES_LOAD); end
   endtask

   task automatic test_store();
      reset_dut(); instr = I_SW;
      run_insn(0, 0, 0, 1'b0, 20);
      checks++; if (r_retire_cyc !== 3 || r_dmem_we !== 1'b1) begin errors++; $display("[TB] FAIL sw_retire: got cyc=%0d we=%0b expected 3/1", r_retire_cyc, r_dmem_we); end
      checks++; if (r_reg_write !== 0 || r_pc_write !== 1 || r_pc_src !== 1'b0) begin errors++; $display("[TB] FAIL sw_pc: got rw=%0d pw=%0d pc_src=%0b expected 0/1/0", r_reg_write, r_pc_write, r_pc_src); end
      checks++; if (r_imm !== IMM_S) begin errors++; $display("[TB] FAIL sw_imm: got %0d expected %0d", r_imm, IMM_S); end
   endtask

   task automatic test_back_to_back_branches();
      reset_dut(); instr = I_BEQ;
      for (int k = 0; k < 2; k++) begin
         logic bc;
         bc = (k == 0);
         run_insn(0, 0, 0, bc, 20);
         checks++; if (r_retire_cyc !== 2 || r_pc_write !== 1) begin errors++; $display("[TB] FAIL beq%0d_retire: got cyc=%0d pw=%0d expected 2/1", k, r_retire_cyc, r_pc_write); end
         checks++; if (r_pc_src !== bc || r_reg_write !== 0) begin errors++; $display("[TB] FAIL beq%0d_pc_src: got pc_src=%0b rw=%0d expected %0b/0", k, r_pc_src, r_reg_write, bc); end
         checks++; if (r_alu !== ALU_EQ || r_imm !== IMM_B) begin errors++; $display("[TB] FAIL beq%0d_codes: got alu=%0d imm=%0d expected %0d/%0d", k, r_alu, r_imm, ALU_EQ, IMM_B); end
         checks++; if (r_first_instret !== k) begin errors++; $display("[TB] FAIL beq%0d_instret: got %0d expected %0d", k, r_first_instret, k); end
      end
   endtask

   task automatic test_jumps();
      reset_dut(); instr = I_JAL;
      run_insn(0, 0, 0, 1'b0, 20);
      checks++; if (r_retire_cyc !== 3 || r_pc_src !== 1'b1 || r_reg_write !== 1) begin errors++; $display("[TB] FAIL jal_wb: got cyc=%0d pc_src=%0b rw=%0d expected 3/1/1", r_retire_cyc, r_pc_src, r_reg_write); end
      checks++; if (r_res !== RES_PC4 || r_base !== 1'b1 || r_imm !== IMM_J) begin errors++; $display("[TB] FAIL jal_codes: got res=%0d base=%0b imm=%0d expected %0d/1/%0d", r_res, r_base, r_imm, RES_PC4, IMM_J); end
      instr = I_JALR;
      run_insn(0, 0, 0, 1'b0, 20);
      checks++; if (r_pc_src !== 1'b1 || r_reg_write !== 1 || r_base !== 1'b0) begin errors++; $display("[TB] FAIL jalr_x0: got pc_src=%0b rw=%0d base=%0b expected 1/1/0", r_pc_src, r_reg_write, r_base); end
   endtask

   task automatic test_muldiv();
      reset_dut(); instr = I_DIV;
      run_insn(0, 0, 33, 1'b0, 60);
      checks++; if (r_md_start !== 1 || r_start_cyc !== 2) begin errors++; $display("[TB] FAIL div_start: got count=%0d cyc=%0d expected 1/2", r_md_start, r_start_cyc); end
      checks++; if (r_retire_cyc - r_start_cyc !== 34) begin errors++; $display("[TB] FAIL div_execute_len: got %0d expected 34", r_retire_cyc - r_start_cyc); end
      checks++; if (r_reg_write !== 1 || r_alu !== ALU_DIV || r_timeout !== 1'b0) begin errors++; $display("[TB] FAIL div_wb: got rw=%0d alu=%0d to=%0b expected 1/%0d/0", r_reg_write, r_alu, r_timeout, ALU_DIV); end
   endtask

   task automatic test_illegal();
      reset_dut(); instr = I_BAD;
`ifdef ILLEGAL_INSN_TRAP_EN
      int late_req;
      run_insn(0, 0, 0, 1'b0, 20);
      checks++; if (r_timeout !== 1'b1 || r_trap !== 1'b1) begin errors++; $display("[TB] FAIL bad_trap: got to=%0b trap=%0b expected 1/1", r_timeout, r_trap); end
      checks++; if (r_imem_req !== 1 || r_pc_write !== 0) begin errors++; $display("[TB] FAIL bad_trap_fetch: got req=%0d pw=%0d expected 1/0", r_imem_req, r_pc_write); end
      late_req = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (imem_req) late_req++;
      end
      checks++; if (late_req !== 0 || trap !== 1'b1) begin errors++; $display("[TB] FAIL bad_trap_sticky: got req=%0d trap=%0b expected 0/1", late_req, trap); end
`else
      run_insn(0, 0, 0, 1'b0, 20);
      checks++; if (r_retire_cyc !== 2 || r_reg_write !== 0) begin errors++; $display("[TB] FAIL bad_nop: got cyc=%0d rw=%0d expected 2/0", r_retire_cyc, r_reg_write); end
      checks++; if (r_pc_write !== 1 || r_pc_src !== 1'b0 || r_trap !== 1'b0) begin errors++; $display("[TB] FAIL bad_nop_pc: got pw=%0d pc_src=%0b trap=%0b expected 1/0/0", r_pc_write, r_pc_src, r_trap); end
`endif
   endtask

   task automatic test_m_ext_off();
      int first_ret, rw_m0, md_m0, req_m0, md_m1;
      reset_dut(); instr = I_MUL; imem_ready = 1'b1;
      first_ret = -1; rw_m0 = 0; md_m0 = 0; req_m0 = 0; md_m1 = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #2;
         if (retire_m0 && first_ret < 0) first_ret = c;
         if (reg_write_m0) rw_m0++;
         if (muldiv_start_m0) md_m0++;
         if (imem_req_m0) req_m0++;
         if (muldiv_start) md_m1++;
      end
      checks++; if (md_m1 !== 1 || md_m0 !== 0) begin errors++; $display("[TB] FAIL mul_start: got m1=%0d m0=%0d expected 1/0", md_m1, md_m0); end
`ifdef ILLEGAL_INSN_TRAP_EN
      checks++; if (trap_m0 !== 1'b1 || req_m0 !== 1 || first_ret !== -1) begin errors++; $display("[TB] FAIL mul_m0_trap: got trap=%0b req=%0d ret=%0d expected 1/1/-1", trap_m0, req_m0, first_ret); end
`else
      checks++; if (first_ret !== 2 || rw_m0 !== 0 || trap_m0 !== 1'b0) begin errors++; $display("[TB] FAIL mul_m0_nop: got ret=%0d rw=%0d trap=%0b expected 2/0/0", first_ret, rw_m0, trap_m0); end
`endif
   endtask

   task automatic test_wrap_and_abort();
      reset_dut(); instr = I_ADDI;
      for (int i = 0; i < 16; i++) begin
         run_insn(0, 0, 0, 1'b0, 20);
         if (i == 15) begin
            checks++; if (r_first_instret !== 32'd15) begin errors++; $display("[TB] FAIL wrap_pre: got %0d expected 15", r_first_instret); end
         end
      end
      @(posedge clk); #1;
      checks++; if (instret_m0 !== 4'd0 || instret !== 32'd16) begin errors++; $display("[TB] FAIL wrap_instret: got m0=%0d m1=%0d expected 0/16", instret_m0, instret); end
      reset_dut(); instr = I_ADDI;
      run_insn(0, 0, 0, 1'b0, 20);
      instr = I_LW;
      run_insn(0, 100, 0, 1'b0, 4);
      checks++; if (dmem_req !== 1'b1 || instret !== 32'd1) begin errors++; $display("[TB] FAIL abort_pre: got req=%0b instret=%0d expected 1/1", dmem_req, instret); end
      rst_n = 1'b0; #1;
      checks++; if (dmem_req !== 1'b0 || instret !== 32'd0) begin errors++; $display("[TB] FAIL abort_drop: got req=%0b instret=%0d expected 0/0", dmem_req, instret); end
      checks++; if ({retire, reg_write, pc_write} !== 3'b000 || alu_control !== 5'd0) begin errors++; $display("[TB] FAIL abort_pulses: got %b alu=%0d expected 000/0", {retire, reg_write, pc_write}, alu_control); end
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; instr = 32'd0; imem_ready = 1'b0; dmem_ready = 1'b0;
      muldiv_done = 1'b0; branch_cond = 1'b0;
      test_reset();
      test_alu_fetch();
      test_wait_states();
      test_store();
      test_back_to_back_branches();
      test_jumps();
      test_muldiv();
      test_illegal();
      test_m_ext_off();
      test_wrap_and_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
